// File: rtl/axil_pkg.sv
// Shared AXI-Lite response codes and channel FSM state encodings.
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_EXEC = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axil_regfile_array.sv
// Register storage with byte-strobe writes, per-register write pulses and an
// index-selected combinational read port.
module axil_regfile_array
  import axil_pkg::*;
#(
  parameter int unsigned   DATA_W   = 32,
  parameter int unsigned   NUM_REGS = 16,
  localparam int unsigned  IDX_W    = $clog2(NUM_REGS),
  localparam int unsigned  STRB_W   = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [STRB_W-1:0]            wstrb_i,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic [DATA_W-1:0]            rd_data_c,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
  output logic [NUM_REGS-1:0]          pulse_o
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (we_i) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) regs_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
        if (|wstrb_i) pulse_q[idx_i] <= 1'b1;
      end
    end
  end

  assign rd_data_c = regs_q[rd_idx_i];
  assign pulse_o   = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign reg_q_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register file: independent write/read channel FSMs over a
// strobe-writable register array. AXIL_REGFILE_STATUS_EN maps the upper half to hw_status.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 16
) (
  input  logic                                aclk,
  input  logic                                aresetn,
`ifdef AXIL_REGFILE_STATUS_EN
  input  logic [(NUM_REGS/2)*AXI_DATA_WIDTH-1:0] hw_status,
`endif
  input  logic [AXI_ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic                                s_axil_awvalid,
  output logic                                s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]         s_axil_wstrb,
  input  logic                                s_axil_wvalid,
  output logic                                s_axil_wready,
  output logic [1:0]                          s_axil_bresp,
  output logic                                s_axil_bvalid,
  input  logic                                s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic                                s_axil_arvalid,
  output logic                                s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                          s_axil_rresp,
  output logic                                s_axil_rvalid,
  input  logic                                s_axil_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]  reg_q,
  output logic [NUM_REGS-1:0]                 reg_wr_pulse
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned TOP_LSB  = ADDR_LSB + IDX_W;

  // Address decode: index field plus "no upper bits set" range check
  logic             aw_in_range_c, ar_in_range_c;
  logic [IDX_W-1:0] aw_idx_c, ar_idx_c;
  logic             unused_addr_lsbs;

  assign aw_idx_c      = s_axil_awaddr[ADDR_LSB +: IDX_W];
  assign ar_idx_c      = s_axil_araddr[ADDR_LSB +: IDX_W];
  assign aw_in_range_c = (s_axil_awaddr[AXI_ADDR_WIDTH-1:TOP_LSB] == '0);
  assign ar_in_range_c = (s_axil_araddr[AXI_ADDR_WIDTH-1:TOP_LSB] == '0);
  assign unused_addr_lsbs = ^{s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

  // Write channel state
  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic                aw_ok_q, aw_ok_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                wr_commit_c, wr_writable_c;
  logic [1:0]          wr_resp_c;

  // Read channel state
  rd_state_e           rd_state_q, rd_state_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, arr_rd_data_c, rd_word_c;
  logic [1:0]          rresp_q, rresp_d;

  always_comb begin
    wr_writable_c = aw_ok_q;
    wr_resp_c     = aw_ok_q ? AXIL_RESP_OKAY : AXIL_RESP_DECERR;
`ifdef AXIL_REGFILE_STATUS_EN
    if (aw_ok_q && aw_idx_q[IDX_W-1]) begin
      wr_writable_c = 1'b0;
      wr_resp_c     = AXIL_RESP_SLVERR;
    end
`endif
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    aw_idx_d    = aw_idx_q;
    aw_ok_d     = aw_ok_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_commit_c = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axil_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = aw_idx_c;
          aw_ok_d   = aw_in_range_c;
        end
        if (s_axil_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          wr_state_d = WR_EXEC;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      WR_EXEC: begin
        wr_commit_c = 1'b1;
        bvalid_d    = 1'b1;
        bresp_d     = wr_resp_c;
        wr_state_d  = WR_RESP;
      end
      WR_RESP: begin
        if (s_axil_bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      aw_ok_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXIL_RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      aw_ok_q    <= aw_ok_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read source: storage, or live status words for the upper half when enabled
`ifdef AXIL_REGFILE_STATUS_EN
  logic [IDX_W-1:0] status_off_c;
  assign status_off_c = ar_idx_c - IDX_W'(NUM_REGS / 2);
`endif

  always_comb begin
    rd_word_c = arr_rd_data_c;
`ifdef AXIL_REGFILE_STATUS_EN
    if (ar_idx_c[IDX_W-1])
      rd_word_c = hw_status[status_off_c*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
`endif
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axil_arvalid && arready_q) begin
          rvalid_d   = 1'b1;
          rdata_d    = ar_in_range_c ? rd_word_c : '0;
          rresp_d    = ar_in_range_c ? AXIL_RESP_OKAY : AXIL_RESP_DECERR;
          rd_state_d = RD_RESP;
        end else begin
          arready_d = 1'b1;
        end
      end
      RD_RESP: begin
        if (s_axil_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= AXIL_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  axil_regfile_array #(
    .DATA_W   (AXI_DATA_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_array (
    .clk       (aclk),
    .rst_n     (aresetn),
    .we_i      (wr_commit_c && wr_writable_c),
    .idx_i     (aw_idx_q),
    .wdata_i   (wdata_q),
    .wstrb_i   (wstrb_q),
    .rd_idx_i  (ar_idx_c),
    .rd_data_c (arr_rd_data_c),
    .reg_q_o   (reg_q),
    .pulse_o   (reg_wr_pulse)
  );

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Scoreboard bench for axil_slave_regfile: stimulus queues expected B/R
// responses, a negedge monitor pops and compares them on each handshake.
module tb_axil_slave_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 16;

  logic              aclk;
  logic              aresetn;
  logic [AW-1:0]     s_axil_awaddr;
  logic              s_axil_awvalid, s_axil_awready;
  logic [DW-1:0]     s_axil_wdata;
  logic [DW/8-1:0]   s_axil_wstrb;
  logic              s_axil_wvalid, s_axil_wready;
  logic [1:0]        s_axil_bresp;
  logic              s_axil_bvalid, s_axil_bready;
  logic [AW-1:0]     s_axil_araddr;
  logic              s_axil_arvalid, s_axil_arready;
  logic [DW-1:0]     s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic              s_axil_rvalid, s_axil_rready;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     reg_wr_pulse;
`ifdef AXIL_REGFILE_STATUS_EN
  logic [(NR/2)*DW-1:0] hw_status;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  axil_slave_regfile #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .aresetn(aresetn),
`ifdef AXIL_REGFILE_STATUS_EN
    .hw_status(hw_status),
`endif
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  // Monitor: one compare per B/R handshake (sampled on the falling edge)
  always @(negedge aclk) begin
    if (s_axil_bvalid && s_axil_bready) begin
      if (bq.size() == 0) chk("unexpected_b", {62'd0, s_axil_bresp}, 64'hFFFF);
      else chk("bresp", {62'd0, s_axil_bresp}, {62'd0, bq.pop_front()});
    end
    if (s_axil_rvalid && s_axil_rready) begin
      if (rq.size() == 0) chk("unexpected_r", {30'd0, s_axil_rresp, s_axil_rdata}, 64'hFFFF_FFFF_FFFF);
      else chk("rresp_rdata", {30'd0, s_axil_rresp, s_axil_rdata}, {30'd0, rq.pop_front()});
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, output logic [NR-1:0] pulse);
    int n;
    logic aw_hs, w_hs;
    bq.push_back(resp);
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    n = 0;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 20) begin
      @(negedge aclk);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      tick();
      if (aw_hs) s_axil_awvalid = 1'b0;
      if (w_hs)  s_axil_wvalid  = 1'b0;
      n++;
    end
    if (n >= 20) chk("write_addr_data_timeout", 64'd1, 64'd0);
    pulse = '0;
    n = 0;
    while (n < 20) begin
      @(negedge aclk);
      if (s_axil_bvalid) break;
      n++;
    end
    if (n >= 20) chk("bvalid_timeout", 64'd1, 64'd0);
    else pulse = reg_wr_pulse;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int n;
    logic hs;
    rq.push_back({resp, data});
    s_axil_araddr = addr; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge aclk);
      hs = s_axil_arready;
      tick();
      if (hs) break;
      n++;
    end
    s_axil_arvalid = 1'b0;
    if (n >= 20) chk("ar_timeout", 64'd1, 64'd0);
    n = 0;
    while (n < 20) begin
      @(negedge aclk);
      if (s_axil_rvalid) break;
      n++;
    end
    if (n >= 20) chk("rvalid_timeout", 64'd1, 64'd0);
    tick();
    s_axil_rready = 1'b0;
  endtask

  initial begin
    logic [NR-1:0]    p;
    logic [NR*DW-1:0] snap;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
`ifdef AXIL_REGFILE_STATUS_EN
    hw_status = '0;
`endif
    aresetn = 1'b0;
    repeat (3) tick();

    // Reset values and ready rise one cycle after release
    chk("rst_hs_outputs", {59'd0, s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}, 64'd0);
    chk("rst_resp_data", {30'd0, s_axil_bresp, s_axil_rresp, s_axil_rdata}, 64'd0);
    chk("rst_regs_pulse", {63'd0, (reg_q == '0) && (reg_wr_pulse == '0)}, 64'd1);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("ready_before_edge", {61'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'd0);
    tick();
    @(negedge aclk);
    chk("ready_after_edge", {61'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'd7);
    tick();

    // Basic write/read of reg 1
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 2'b00, p);
    chk("pulse_reg1", {48'd0, p}, 64'h0002);
    chk("pulse_one_cycle", {48'd0, reg_wr_pulse}, 64'd0);
    do_read(32'h04, 32'hDEADBEEF, 2'b00);

    // W handshake three cycles ahead of AW
    bq.push_back(2'b00);
    s_axil_bready = 1'b1;
    s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(negedge aclk);
    chk("w_first_ready", {63'd0, s_axil_wready}, 64'd1);
    tick();
    s_axil_wvalid = 1'b0;
    @(negedge aclk);
    chk("w_held_ready_low", {62'd0, s_axil_wready, s_axil_awready}, 64'd1);
    tick();
    tick();
    s_axil_awaddr = 32'h08; s_axil_awvalid = 1'b1;
    @(negedge aclk);
    chk("aw_late_ready", {63'd0, s_axil_awready}, 64'd1);
    tick();
    s_axil_awvalid = 1'b0;
    @(negedge aclk);
    chk("bvalid_lat_cycle1", {63'd0, s_axil_bvalid}, 64'd0);
    tick();
    @(negedge aclk);
    chk("bvalid_lat_cycle2", {63'd0, s_axil_bvalid}, 64'd1);
    tick();
    s_axil_bready = 1'b0;
    chk("reg2_value", {32'd0, reg_q[2*DW +: DW]}, 64'h12345678);
    do_read(32'h08, 32'h12345678, 2'b00);

    // Byte strobes
    do_write(32'h00, 32'hFFFFFFFF, 4'hF, 2'b00, p);
    do_write(32'h00, 32'h00000000, 4'h5, 2'b00, p);
    chk("pulse_reg0", {48'd0, p}, 64'h0001);
    chk("reg0_strobed", {32'd0, reg_q[0 +: DW]}, 64'hFF00FF00);
    do_read(32'h00, 32'hFF00FF00, 2'b00);

    // Out of range and address boundaries
    snap = reg_q;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 2'b11, p);
    chk("oor_no_pulse", {48'd0, p}, 64'd0);
    chk("oor_no_change", {63'd0, reg_q == snap}, 64'd1);
    do_read(32'h40, 32'h0, 2'b11);
    do_read(32'h10000004, 32'h0, 2'b11);
    do_read(32'h3F, 32'h0, 2'b00);
    do_read(32'h07, 32'hDEADBEEF, 2'b00);

    // Zero strobe in range: OKAY, no pulse, no change
    do_write(32'h04, 32'h0, 4'h0, 2'b00, p);
    chk("zero_strb_no_pulse", {48'd0, p}, 64'd0);
    do_read(32'h04, 32'hDEADBEEF, 2'b00);

    // B backpressure on a DECERR response
    bq.push_back(2'b11);
    s_axil_awaddr = 32'h80; s_axil_wdata = 32'h1; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("b_backpressure", {59'd0, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready}, 64'b11100);
      tick();
    end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;

    // R backpressure
    rq.push_back({2'b00, 32'hDEADBEEF});
    s_axil_araddr = 32'h04; s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("r_backpressure", {29'd0, s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_arready}, {29'd0, 1'b1, 2'b00, 32'hDEADBEEF, 1'b0});
      tick();
    end
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;

    // Same-cycle read and write of reg 3 returns the old value
    do_write(32'h0C, 32'h1, 4'hF, 2'b00, p);
    fork
      do_write(32'h0C, 32'h2, 4'hF, 2'b00, p);
      do_read(32'h0C, 32'h1, 2'b00);
    join
    do_read(32'h0C, 32'h2, 2'b00);

    // Reset while a write response is pending
    s_axil_awaddr = 32'h14; s_axil_wdata = 32'h55; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    tick();
    @(negedge aclk);
    chk("pending_bvalid", {63'd0, s_axil_bvalid}, 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_outputs", {60'd0, s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_arready}, 64'd0);
    chk("mid_rst_regs", {63'd0, reg_q == '0}, 64'd1);
    tick();
    aresetn = 1'b1;
    tick();
    do_read(32'h04, 32'h0, 2'b00);
    do_read(32'h08, 32'h0, 2'b00);
    do_read(32'h0C, 32'h0, 2'b00);
    do_read(32'h14, 32'h0, 2'b00);

    repeat (3) tick();
    chk("b_queue_drained", 64'(bq.size()), 64'd0);
    chk("r_queue_drained", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_slave_regfile.md
Name: axil_slave_regfile

Overview:
- AXI-Lite slave (responder) terminating the AXI-Lite master port, exposing NUM_REGS memory-mapped registers to fabric logic.
- Independent write and read channel FSMs.
- Full byte-strobe support and per-register write pulses.
- Out-of-range accesses return DECERR.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width; 32 or 64 only.
- AXI_ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 16, register count; power of two, 2..256.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  AXI_DATA_WIDTH  write data
- s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  AXI_DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data ready
- reg_q  out  NUM_REGS*AXI_DATA_WIDTH  register contents; reg i at slice [i*W +: W]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse when reg i is written (any strobe set)

Behaviour:
- Reset (aresetn low, asynchronous): all registers 0; all ready/valid outputs 0; bresp, rresp, rdata 0; reg_wr_pulse 0; both FSMs idle.
- Ready outputs rise one cycle after reset release.
- Decode:
  - ADDR_LSB = log2(AXI_DATA_WIDTH/8); idx = addr[ADDR_LSB +: log2(NUM_REGS)].
  - Address bits below ADDR_LSB are ignored.
  - In range iff addr >> ADDR_LSB < NUM_REGS; any set upper bit means out of range.
- Write FSM states:
  - WR_IDLE: awready = !aw_held; wready = !w_held.
    - AW and W handshakes are captured independently in any order or together; held flags are set.
    - When both are held, or the final one arrives this cycle, go to WR_EXEC.
  - WR_EXEC (1 cycle): commit bytes whose wstrb bit is set; pulse reg_wr_pulse[idx] if in range and wstrb != 0.
    - bresp = OKAY (2'b00), or DECERR (2'b11) with no register change if out of range.
    - Assert bvalid; go to WR_RESP.
  - WR_RESP: hold bvalid and bresp stable until bready; on handshake clear held flags and go to WR_IDLE.
  - awready and wready are 0 in WR_EXEC and WR_RESP.
  - Latency: bvalid rises 2 cycles after the later of the AW/W handshakes.
- Read FSM states:
  - RD_IDLE: arready = 1. On AR handshake, capture rdata and rresp from current register state and go to RD_RESP; rvalid rises next cycle.
  - RD_RESP: arready = 0; rvalid, rdata, rresp stable until rready; then back to RD_IDLE.
  - Out-of-range read: rdata = 0, rresp = DECERR.
- Simultaneous read and write of the same register: the read captures the pre-write value; the write is committed in WR_EXEC after capture.
- wstrb = 0 in range: no change, no pulse, bresp OKAY.
- Back-to-back transactions: at most one outstanding write and one outstanding read.
- Reset asserted mid-transaction: all state cleared immediately; no response is issued for the aborted transaction.

Optional Feature:
- AXIL_REGFILE_STATUS_EN defined:
  - Adds input port hw_status  in  (NUM_REGS/2)*AXI_DATA_WIDTH.
  - Upper half of the register map (idx >= NUM_REGS/2) reads live hw_status slices, sampled at the AR handshake.
  - Writes to the upper half return SLVERR (2'b10), change no state, and produce no pulse.
  - reg_q upper-half slices read 0.
- Undefined: all registers are read/write storage; no hw_status port.

Decomposition:
- Package axil_pkg:
  - resp constants AXIL_RESP_OKAY=2'b00, AXIL_RESP_SLVERR=2'b10, AXIL_RESP_DECERR=2'b11.
  - Write FSM and read FSM state enums.
- Sub-module axil_regfile_array: register storage with byte-strobe write, write pulse generation, and combinational read mux by index.
- Top module holds both channel FSMs and address decode.

Test Plan:
- Reset release: all outputs 0; awready, wready, arready = 1 one cycle later. Write 0xDEADBEEF to 0x04 (wstrb 0xF) → bresp 00; reg_wr_pulse[1] one cycle; read 0x04 → rdata 0xDEADBEEF, rresp 00.
- W handshake 3 cycles before AW, addr 0x08, data 0x12345678 → single write; bvalid 2 cycles after AW handshake; reg 2 = 0x12345678.
- Byte strobes: reg 0 = 0xFFFFFFFF, write 0x00000000 with wstrb 0x5 → reg 0 = 0xFF00FF00.
- Out of range, NUM_REGS=16: write 0x40 → bresp 11, no pulse, no register change; read 0x40 → rdata 0, rresp 11.
- Backpressure: hold bready low 5 cycles → bvalid and bresp stable, awready 0; hold rready low 5 cycles → rvalid and rdata stable. Same-cycle read and write of reg 3 (old value 0x1, new value 0x2) → read returns 0x1.
- Mid-transaction reset: assert aresetn low during WR_RESP → bvalid drops immediately; all registers read 0 after release.
